// File: rtl/sa_pkg.sv
// Shared defaults and state encoding for the systolic-array feeder.
package sa_pkg;
    localparam int SA_DATA_W = 8;
    localparam int SA_ROWS   = 4;
    localparam int SA_COLS   = 4;

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} sa_feed_state_t;
endpackage

// File: rtl/sa_skew_line.sv
// DEPTH-stage valid+data delay line; one per PE row to build the diagonal skew.
module sa_skew_line
    import sa_pkg::*;
#(
    parameter int DATA_W = SA_DATA_W,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] dat_o
);
    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0][DATA_W-1:0] dat_q;

    // Advance one stage every cycle; bubbles travel like data. Clear flushes all stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            dat_q[0] <= dat_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign dat_o = dat_q[DEPTH-1];
endmodule

// File: rtl/sa_feeder.sv
// Left/weight-edge feeder for a weight-stationary systolic array: weight preload
// with one-hot row strobes, then skewed activation streaming and drain.
module sa_feeder
    import sa_pkg::*;
#(
    parameter int DATA_W = SA_DATA_W,
    parameter int ROWS   = SA_ROWS,
    parameter int COLS   = SA_COLS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   reload_w,
    output logic                   busy,
    output logic                   done,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [COLS*DATA_W-1:0] w_data,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [ROWS*DATA_W-1:0] a_data,
    input  logic                   a_last,
    output logic [ROWS-1:0]        sa_valid,
    output logic [ROWS-1:0]        sa_load_w,
    output logic [COLS*DATA_W-1:0] sa_weight,
    output logic [ROWS*DATA_W-1:0] sa_act
);
    localparam int              CNT_W     = $clog2(ROWS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ROWS - 1);
    // Drain counts 0..ROWS: the last vector needs ROWS cycles to leave row ROWS-1,
    // and the extra cycle is the done cycle.
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(ROWS);

    sa_feed_state_t          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ROWS-1:0]         load_q, load_d;
    logic [COLS*DATA_W-1:0]  weight_q, weight_d;
    logic [ROWS-1:0]         skew_vld;
    logic                    w_hs, a_hs;

    assign w_ready = (state_q == LOAD_W);
    assign a_ready = (state_q == STREAM);
    assign w_hs    = w_valid & w_ready;
    assign a_hs    = a_valid & a_ready;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DRAIN) && (cnt_q == DRAIN_END);

    // State, counter and weight-edge registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            load_q   <= '0;
            weight_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            weight_q <= weight_d;
        end
    end

    // Next-state, beat/drain counting and weight strobe generation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_d   = '0;
        weight_d = weight_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = reload_w ? LOAD_W : STREAM;
                end
            end
            LOAD_W: begin
                if (w_hs) begin
                    load_d   = ROWS'(1) << cnt_q;
                    weight_d = w_data;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = STREAM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            STREAM: begin
                if (a_hs && a_last) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row r is delayed r+1 registers; non-handshake cycles inject zero bubbles.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        sa_skew_line #(
            .DATA_W (DATA_W),
            .DEPTH  (r + 1)
        ) u_line (
            .clk   (clk),
            .rst   (rst),
            .vld_i (a_hs),
            .dat_i (a_hs ? a_data[r*DATA_W +: DATA_W] : '0),
            .vld_o (skew_vld[r]),
            .dat_o (sa_act[r*DATA_W +: DATA_W])
        );
    end

    // Load strobes and stream valids never overlap: the skew lines are empty during LOAD_W.
    assign sa_valid  = skew_vld | load_q;
    assign sa_load_w = load_q;
    assign sa_weight = weight_q;
endmodule

// File: tb/tb_sa_feeder.sv
// Scoreboard bench for sa_feeder: stimulus pushes expected events, a negedge monitor pops them.
module tb_sa_feeder;
    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0, reload_w = 1'b0;
    logic            w_valid = 1'b0, a_valid = 1'b0, a_last = 1'b0;
    logic [C*DW-1:0] w_data = '0;
    logic [R*DW-1:0] a_data = '0;
    logic            busy, done, w_ready, a_ready;
    logic [R-1:0]    sa_valid, sa_load_w;
    logic [C*DW-1:0] sa_weight;
    logic [R*DW-1:0] sa_act;

    sa_feeder #(.DATA_W(DW), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst(rst), .start(start), .reload_w(reload_w),
        .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .sa_valid(sa_valid), .sa_load_w(sa_load_w), .sa_weight(sa_weight), .sa_act(sa_act)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    logic stray = 1'b0;

    typedef struct { int cy; int row; logic [DW-1:0] d; } aexp_t;
    typedef struct { int cy; int k; logic [C*DW-1:0] w; } wexp_t;
    aexp_t aq[$];
    wexp_t wq[$];
    int    dq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents load beats, row valids or done.
    logic prev_done = 1'b0;
    int   idx;
    always @(negedge clk) begin
        if (!rst) begin
            if (|sa_load_w) begin
                if (wq.size() == 0) chk("unexpected load_w", 64'(sa_load_w), 0);
                else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("load cycle", cyc, e.cy);
                    chk("load_w", 64'(sa_load_w), 64'(1) << e.k);
                    chk("load valid", 64'(sa_valid), 64'(1) << e.k);
                    chk("weight", 64'(sa_weight), 64'(e.w));
                end
            end else begin
                for (int r = 0; r < R; r++) begin
                    if (sa_valid[r]) begin
                        idx = -1;
                        for (int i = 0; i < aq.size(); i++)
                            if (idx < 0 && aq[i].row == r) idx = i;
                        if (idx < 0) chk($sformatf("row%0d unexpected valid", r), 1, 0);
                        else begin
                            chk($sformatf("row%0d cycle", r), cyc, aq[idx].cy);
                            chk($sformatf("row%0d act", r), 64'(sa_act[r*DW +: DW]), 64'(aq[idx].d));
                            aq.delete(idx);
                        end
                    end else begin
                        chk($sformatf("row%0d bubble data", r), 64'(sa_act[r*DW +: DW]), 0);
                    end
                end
            end
            for (int i = aq.size() - 1; i >= 0; i--)
                if (aq[i].cy < cyc) begin
                    chk($sformatf("row%0d missing valid", aq[i].row), cyc, aq[i].cy);
                    aq.delete(i);
                end
            if (done) begin
                if (dq.size() == 0) chk("spurious done", 1, 0);
                else chk("done cycle", cyc, dq.pop_front());
                chk("busy at done", busy, 1);
            end
            if (prev_done) chk("busy after done", busy, 0);
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic reload, input logic last_noise);
        tick();
        start = 1'b1; reload_w = reload;
        a_valid = 1'b0; a_last = last_noise; w_valid = 1'b0;
    endtask

    task automatic beat(input int k, input logic [C*DW-1:0] w);
        tick();
        chk("w_ready in load", w_ready, 1);
        chk("a_ready in load", a_ready, 0);
        start = stray; w_valid = 1'b1; w_data = w; a_valid = 1'b0; a_last = 1'b0;
        wq.push_back('{cyc + 1, k, w});
    endtask

    task automatic vec(input logic [R*DW-1:0] d, input logic last);
        tick();
        chk("a_ready in stream", a_ready, 1);
        chk("w_ready in stream", w_ready, 0);
        start = stray; w_valid = stray; w_data = 32'hFFEE_DDCC;
        a_valid = 1'b1; a_data = d; a_last = last;
        for (int r = 0; r < R; r++) aq.push_back('{cyc + 1 + r, r, d[r*DW +: DW]});
        if (last) dq.push_back(cyc + R + 1);
    endtask

    task automatic gap(input logic last_noise);
        tick();
        a_valid = 1'b0; a_data = 32'hDEAD_BEEF; a_last = last_noise;
    endtask

    // Run out the drain; a stray start is held through the done cycle and dropped once idle.
    task automatic finish_job();
        int n;
        for (n = 0; n < 30; n++) begin
            tick();
            if (aq.size() == 0 && dq.size() == 0 && !busy) break;
            a_valid = 1'b0; a_last = 1'b0; start = stray; w_valid = stray;
        end
        chk("job completes in budget", n < 30, 1);
        start = 1'b0; w_valid = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("reset ctrl outputs", {busy, done, w_ready, a_ready, sa_valid, sa_load_w}, 0);
        chk("reset sa_weight", 64'(sa_weight), 0);
        chk("reset sa_act", 64'(sa_act), 0);
        rst = 1'b0;

        // Weight preload followed by a gap-free three-vector job
        start_job(1'b1, 1'b0);
        for (int k = 0; k < R; k++) beat(k, 32'h0403_0201 + 32'h0101_0101 * k);
        vec(32'h1312_1110, 1'b0);
        vec(32'h2322_2120, 1'b0);
        vec(32'h3332_3130, 1'b1);
        finish_job();

        // Resident weights, two-cycle bubble; a_last without a_valid inside the bubble
        start_job(1'b0, 1'b0);
        vec(32'h1312_1110, 1'b0);
        vec(32'h2322_2120, 1'b0);
        gap(1'b1);
        gap(1'b1);
        vec(32'h3332_3130, 1'b1);
        finish_job();

        // Reset after one vector, then a fresh job started right as rst falls
        start_job(1'b0, 1'b0);
        vec(32'h4342_4140, 1'b0);
        tick();
        rst = 1'b1; a_valid = 1'b0; start = 1'b0;
        tick();
        aq.delete(); dq.delete();
        chk("abort ctrl outputs", {busy, done, w_ready, a_ready, sa_valid, sa_load_w}, 0);
        chk("abort sa_weight", 64'(sa_weight), 0);
        chk("abort sa_act", 64'(sa_act), 0);
        rst = 1'b0; start = 1'b1; reload_w = 1'b0;
        vec(32'h5352_5150, 1'b0);
        vec(32'h6362_6160, 1'b0);
        vec(32'h7372_7170, 1'b1);
        finish_job();

        // Stray start / w_valid while busy, a_last without a_valid while idle
        stray = 1'b1;
        start_job(1'b0, 1'b1);
        vec(32'h1312_1110, 1'b0);
        vec(32'h2322_2120, 1'b0);
        vec(32'h3332_3130, 1'b1);
        finish_job();
        stray = 1'b0;
        repeat (3) tick();
        chk("idle after stray job", busy, 0);

        chk("act scoreboard empty", aq.size(), 0);
        chk("weight scoreboard empty", wq.size(), 0);
        chk("done scoreboard empty", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
